sync_down_counter: RTL and testbench
====================================

SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the count width in bits.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port load, input, 1, which loads load_val into count and reload registers.
REQ-005 The module SHALL have port load_val, input, WIDTH, the value to load.
REQ-006 The module SHALL have port start, input, 1, a run request.
REQ-007 The module SHALL have port en, input, 1, a count tick qualifier that is honoured only in RUN.
REQ-008 The module SHALL have port auto_reload, input, 1, which selects periodic mode and is sampled at each terminal tick.
REQ-009 The module SHALL have port out, output, WIDTH, the current count value.
REQ-010 The module SHALL have port busy, output, 1, which is high in state RUN.
REQ-011 The module SHALL have port done, output, 1, which is high in state DONE.
REQ-012 The module SHALL have port tc, output, 1, a registered one-cycle terminal-count pulse.

Function
REQ-013 The block SHALL be a fully synchronous down counter, the counterpart of the codebase's ripple up counter, with no derived or gated clocks.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, and all outputs SHALL be registered.
REQ-015 Priority per edge SHALL be rst > load > start > en.
REQ-016 On load in any state: out<=load_val, reload_reg<=load_val, state->IDLE, tc<=0, and simultaneous start/en SHALL be ignored.
REQ-017 In IDLE, on start with out!=0: state->RUN, out unchanged.
REQ-018 In IDLE, on start with out==0: state->DONE, tc<=1 for one cycle.
REQ-019 In RUN, on en with out>1: out<=out-1.
REQ-020 In RUN, on en with out==1 and auto_reload==0: out<=0, tc<=1, state->DONE.
REQ-021 In RUN, on en with out==1 and auto_reload==1: out<=reload_reg, tc<=1, state stays RUN; the period SHALL equal reload_reg en-ticks.
REQ-022 In RUN with en low, out SHALL hold and start SHALL have no effect.
REQ-023 In DONE, out SHALL remain 0 and en SHALL be ignored.
REQ-024 In DONE, on start with reload_reg!=0: out<=reload_reg, state->RUN.
REQ-025 In DONE, on start with reload_reg==0: stay DONE, tc<=1 for one cycle.
REQ-026 tc SHALL be high for exactly one cycle after each terminal event and SHALL be low otherwise.
REQ-027 out SHALL never wrap from 0 to 2^WIDTH-1, so 0 is a floor.
REQ-028 load_val==2^WIDTH-1 SHALL count the full range, giving 255 ticks to terminal at WIDTH=8.

Reset
REQ-029 When rst is high at a rising clk edge: out=0, reload_reg=0, state=IDLE, busy=0, done=0, tc=0.
REQ-030 rst asserted mid-RUN SHALL abort the count with no tc pulse, and it SHALL override a simultaneous load or start.
REQ-031 rst SHALL have no asynchronous effect; outputs SHALL change only at a clk edge.

Structure
REQ-032 Package sync_down_counter_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the WIDTH default constant.
REQ-033 The bit storage SHALL use one sub-module, dff_sync: a synchronous active-high reset D flip-flop with enable, instantiated per bit for out and reload_reg.
REQ-034 The next-count logic SHALL be a single WIDTH-bit decrement/mux path, with no per-bit ripple clocking.

Verification
REQ-035 Directed test: rst for 2 cycles -> out=0, busy=0, done=0, tc=0, and the same values after a mid-RUN rst.
REQ-036 Directed test: load 5, start, en held high -> out 5,4,3,2,1,0, tc pulses once on the 0 cycle, then done=1 and busy=0.
REQ-037 Directed test: load 3, auto_reload=1, start, en high for 9 cycles -> out 3,2,1,3,2,1,3,2,1, and tc pulses on cycles 3, 6 and 9.
REQ-038 Directed test: load 4, start, en toggling 1,0,1,0 -> out 4,3,3,2,2, and busy stays 1.
REQ-039 Directed test: load and start asserted in the same cycle with load_val=7 -> state IDLE, out=7, busy=0.
REQ-040 Directed test: from DONE with reload_reg=6, start -> out=6, busy=1; then load 0 and start -> done=1 and a single tc pulse.

Source files
------------

// File: rtl/sync_down_counter_pkg.sv
// Shared state encoding and default width for the synchronous down counter.
package sync_down_counter_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/dff_sync.sv
// Single-bit D flip-flop with synchronous active-high reset and write enable.
module dff_sync
    import sync_down_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter with IDLE/RUN/DONE control, optional
// periodic reload and a registered one-cycle terminal-count pulse.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             out_we, reload_we;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Count and reload storage are built from per-bit flops sharing one enable.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
            dff_sync u_out_bit (
                .clk (clk),
                .rst (rst),
                .en  (out_we),
                .d   (out_d[gi]),
                .q   (out_q[gi])
            );
            dff_sync u_reload_bit (
                .clk (clk),
                .rst (rst),
                .en  (reload_we),
                .d   (reload_d[gi]),
                .q   (reload_q[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        reload_d  = reload_q;
        out_we    = 1'b0;
        reload_we = 1'b0;
        tc_d      = 1'b0;

        if (load) begin
            out_d     = load_val;
            reload_d  = load_val;
            out_we    = 1'b1;
            reload_we = 1'b1;
            state_d   = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (out_q != '0) begin
                            state_d = RUN;
                        end else begin
                            state_d = DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        out_we = 1'b1;
                        if (out_q > WIDTH'(1)) begin
                            out_d = out_q - WIDTH'(1);
                        end else if (out_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                out_d = reload_q;
                            end else begin
                                out_d   = '0;
                                state_d = DONE;
                            end
                        end else begin
                            // Already at the floor: never wrap, just retire.
                            out_d   = '0;
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        if (reload_q != '0) begin
                            out_d   = reload_q;
                            out_we  = 1'b1;
                            state_d = RUN;
                        end else begin
                            tc_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign tc   = tc_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed scoreboard bench: the driver queues hand-computed expectations
// per cycle and an independent monitor compares them against the outputs.
module tb_sync_down_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       en;
    logic       auto_reload;
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       tc;

    typedef struct {
        int         cyc;
        logic [7:0] out;
        logic       busy;
        logic       done;
        logic       tc;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cycle     = 0;
    int   chk_cnt   = 0;
    int   pass_cnt  = 0;

    sync_down_counter #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .en          (en),
        .auto_reload (auto_reload),
        .out         (out),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are stable at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cycle = cycle + 1;
            while (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
                e = exp_q.pop_front();
                chk_cnt = chk_cnt + 1;
                if (out === e.out && busy === e.busy && done === e.done && tc === e.tc) begin
                    pass_cnt = pass_cnt + 1;
                    $display("ok   %-12s out=%0d busy=%0b done=%0b tc=%0b", e.name, out, busy, done, tc);
                end else begin
                    $display("FAIL %-12s got out=%0d busy=%0b done=%0b tc=%0b, want out=%0d busy=%0b done=%0b tc=%0b",
                             e.name, out, busy, done, tc, e.out, e.busy, e.done, e.tc);
                end
            end
        end
    end

    task automatic step(input logic r, input logic ld, input logic [7:0] lv,
                        input logic st, input logic e, input logic ar,
                        input logic [7:0] eo, input logic eb, input logic ed,
                        input logic et, input string nm);
        exp_t x;
        @(negedge clk);
        #1;
        rst         = r;
        load        = ld;
        load_val    = lv;
        start       = st;
        en          = e;
        auto_reload = ar;
        x.cyc  = cycle + 1;
        x.out  = eo;
        x.busy = eb;
        x.done = ed;
        x.tc   = et;
        x.name = nm;
        exp_q.push_back(x);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = 8'd0;
        start = 1'b0; en = 1'b0; auto_reload = 1'b0;

        //     rst ld  lv     st  en  ar   out    b  d  tc
        step(1, 0, 8'd0,  0, 0, 0, 8'd0, 0, 0, 0, "reset");
        step(1, 0, 8'd0,  0, 0, 0, 8'd0, 0, 0, 0, "reset");

        // One-shot count from 5
        step(0, 1, 8'd5,  0, 0, 0, 8'd5, 0, 0, 0, "load5");
        step(0, 0, 8'd0,  1, 0, 0, 8'd5, 1, 0, 0, "start5");
        for (int i = 4; i >= 1; i--)
            step(0, 0, 8'd0, 0, 1, 0, 8'(i), 1, 0, 0, "tick5");
        step(0, 0, 8'd0,  0, 1, 0, 8'd0, 0, 1, 1, "term5");
        step(0, 0, 8'd0,  0, 1, 0, 8'd0, 0, 1, 0, "done_en");

        // Run 6 to DONE, then restart from the reload register
        step(0, 1, 8'd6,  0, 0, 0, 8'd6, 0, 0, 0, "load6");
        step(0, 0, 8'd0,  1, 0, 0, 8'd6, 1, 0, 0, "start6");
        for (int i = 5; i >= 1; i--)
            step(0, 0, 8'd0, 0, 1, 0, 8'(i), 1, 0, 0, "tick6");
        step(0, 0, 8'd0,  0, 1, 0, 8'd0, 0, 1, 1, "term6");
        step(0, 0, 8'd0,  1, 0, 0, 8'd6, 1, 0, 0, "restart6");
        step(0, 1, 8'd0,  0, 0, 0, 8'd0, 0, 0, 0, "load0");
        step(0, 0, 8'd0,  1, 0, 0, 8'd0, 0, 1, 1, "start0");
        step(0, 0, 8'd0,  0, 0, 0, 8'd0, 0, 1, 0, "tc_once");
        step(0, 0, 8'd0,  1, 0, 0, 8'd0, 0, 1, 1, "done_rl0");
        step(0, 0, 8'd0,  0, 0, 0, 8'd0, 0, 1, 0, "done_hold");

        // Periodic mode, period 3
        step(0, 1, 8'd3,  0, 0, 1, 8'd3, 0, 0, 0, "load3");
        step(0, 0, 8'd0,  1, 0, 1, 8'd3, 1, 0, 0, "start3");
        for (int k = 1; k <= 9; k++)
            step(0, 0, 8'd0, 0, 1, 1, 8'(3 - (k % 3)), 1, 0, (k % 3) == 0, "auto");
        step(0, 0, 8'd0,  0, 0, 1, 8'd3, 1, 0, 0, "auto_hold");
        step(0, 0, 8'd0,  0, 1, 1, 8'd2, 1, 0, 0, "auto");
        step(0, 0, 8'd0,  0, 1, 1, 8'd1, 1, 0, 0, "auto");
        // Reset beats load/start/en on what would have been a terminal tick
        step(1, 1, 8'd9,  1, 1, 1, 8'd0, 0, 0, 0, "midrun_rst");
        step(0, 0, 8'd0,  0, 0, 0, 8'd0, 0, 0, 0, "post_rst");

        // Gated ticks; start in RUN has no effect
        step(0, 1, 8'd4,  0, 0, 0, 8'd4, 0, 0, 0, "load4");
        step(0, 0, 8'd0,  1, 0, 0, 8'd4, 1, 0, 0, "start4");
        step(0, 0, 8'd0,  0, 1, 0, 8'd3, 1, 0, 0, "en1");
        step(0, 0, 8'd0,  1, 0, 0, 8'd3, 1, 0, 0, "en0_start");
        step(0, 0, 8'd0,  0, 1, 0, 8'd2, 1, 0, 0, "en1");
        step(0, 0, 8'd0,  0, 0, 0, 8'd2, 1, 0, 0, "en0");

        // Load outranks start and en
        step(0, 1, 8'd7,  1, 1, 0, 8'd7, 0, 0, 0, "load_start");
        step(0, 0, 8'd0,  1, 0, 0, 8'd7, 1, 0, 0, "start7");
        step(0, 1, 8'd2,  0, 1, 0, 8'd2, 0, 0, 0, "load_in_run");

        // Full range at WIDTH=8: 255 ticks to terminal
        step(0, 1, 8'd255, 0, 0, 0, 8'd255, 0, 0, 0, "load255");
        step(0, 0, 8'd0,   1, 0, 0, 8'd255, 1, 0, 0, "start255");
        for (int i = 254; i >= 1; i--)
            step(0, 0, 8'd0, 0, 1, 0, 8'(i), 1, 0, 0, "tick255");
        step(0, 0, 8'd0,   0, 1, 0, 8'd0, 0, 1, 1, "term255");
        step(0, 0, 8'd0,   0, 1, 0, 8'd0, 0, 1, 0, "floor");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            chk_cnt = chk_cnt + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
